rj_mem_bank: RTL and testbench

//  Multi-channel Rj coefficient store, parametrised in data width, depth and channel count.

---
 rtl/rj_mem_pkg.sv | 19 +
 rtl/rj_load_ctrl.sv | 100 ++++++++++
 rtl/rj_mem_bank.sv | 125 ++++++++++++
 tb/tb_rj_mem_bank.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rj_mem_pkg.sv
// Shared types and helpers for the Rj coefficient store.
package rj_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    READY
  } rj_load_state_t;

  function automatic int unsigned rj_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Even parity bit; callers zero-extend their word to 64 bits.
  function automatic logic rj_parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/rj_load_ctrl.sv
// Bulk-load sequencer for rj_mem_bank: IDLE/LOAD/READY FSM, load pointers and word count.
// Emits the effective write strobe, channel and address for the storage array.
module rj_load_ctrl
  import rj_mem_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CH_W   = 1,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     frame_i,
  input  logic                     load_en_i,
  input  logic                     wr_en_i,
  input  logic [CH_W-1:0]          wr_ch_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  output logic                     we_o,
  output logic [CH_W-1:0]          we_ch_o,
  output logic [ADDR_W-1:0]        we_addr_o,
  output logic                     load_done_o,
  output logic [CH_W+ADDR_W:0]     load_cnt_o
);

  localparam int unsigned          CNT_W     = CH_W + ADDR_W + 1;
  localparam logic [CH_W-1:0]      LAST_CH   = CH_W'(NUM_CH - 1);
  localparam logic [ADDR_W-1:0]    LAST_WORD = ADDR_W'(DEPTH - 1);

  rj_load_state_t      state_q, state_d;
  logic [CH_W-1:0]     ch_ptr_q, ch_ptr_d;
  logic [ADDR_W-1:0]   word_ptr_q, word_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                done_q, done_d;

  always_ff @(negedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ch_ptr_q   <= '0;
      word_ptr_q <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_ptr_q   <= ch_ptr_d;
      word_ptr_q <= word_ptr_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ch_ptr_d   = ch_ptr_q;
    word_ptr_d = word_ptr_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    we_o       = 1'b0;
    we_ch_o    = wr_ch_i;
    we_addr_o  = wr_addr_i;
    // load_en from any state (re)starts the load and suppresses that edge's write
    if (load_en_i) begin
      state_d    = LOAD;
      ch_ptr_d   = '0;
      word_ptr_d = '0;
      cnt_d      = '0;
      done_d     = 1'b0;
    end else begin
      unique case (state_q)
        LOAD: begin
          if (wr_en_i && frame_i) begin
            we_o      = 1'b1;
            we_ch_o   = ch_ptr_q;
            we_addr_o = word_ptr_q;
            cnt_d     = cnt_q + CNT_W'(1);
            if (word_ptr_q == LAST_WORD) begin
              word_ptr_d = '0;
              if (ch_ptr_q == LAST_CH) begin
                state_d = READY;
                done_d  = 1'b1;
              end else begin
                ch_ptr_d = ch_ptr_q + CH_W'(1);
              end
            end else begin
              word_ptr_d = word_ptr_q + ADDR_W'(1);
            end
          end
        end
        READY: begin
          we_o = wr_en_i && frame_i;
        end
        default: ;
      endcase
    end
    if (rst_i) we_o = 1'b0;
  end

  assign load_done_o = done_q;
  assign load_cnt_o  = cnt_q;

endmodule

// File: rtl/rj_mem_bank.sv
// Multi-channel Rj coefficient store: storage array, registered read port with write-first bypass.
// Optional stored even parity and par_err output when RJ_MEM_PARITY_EN is defined.
module rj_mem_bank
  import rj_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = rj_width(DEPTH),
  parameter int unsigned CH_W   = rj_width(NUM_CH)
) (
  input  logic                 Sclk,
  input  logic                 Reset,
  input  logic                 Frame,
  input  logic                 load_en,
  input  logic                 wr_en,
  input  logic [CH_W-1:0]      wr_ch,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [DATA_W-1:0]    data_in,
  input  logic                 rd_en,
  input  logic [CH_W-1:0]      rd_ch,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [DATA_W-1:0]    Rj,
  output logic                 rd_valid,
  output logic                 load_done,
  output logic [CH_W+ADDR_W:0] load_cnt
`ifdef RJ_MEM_PARITY_EN
  ,
  output logic                 par_err
`endif
);

  logic [DATA_W-1:0] mem [NUM_CH][DEPTH];
  logic              we;
  logic [CH_W-1:0]   we_ch;
  logic [ADDR_W-1:0] we_addr;
  logic              wr_hit;
  logic              rd_in_rng;
  logic [DATA_W-1:0] rj_q, rj_d;
  logic              vld_q, vld_d;

  rj_load_ctrl #(
    .NUM_CH (NUM_CH),
    .DEPTH  (DEPTH),
    .CH_W   (CH_W),
    .ADDR_W (ADDR_W)
  ) u_ctrl (
    .clk_i       (Sclk),
    .rst_i       (Reset),
    .frame_i     (Frame),
    .load_en_i   (load_en),
    .wr_en_i     (wr_en),
    .wr_ch_i     (wr_ch),
    .wr_addr_i   (wr_addr),
    .we_o        (we),
    .we_ch_o     (we_ch),
    .we_addr_o   (we_addr),
    .load_done_o (load_done),
    .load_cnt_o  (load_cnt)
  );

  // Non-power-of-two NUM_CH/DEPTH leave unused codes; those writes are dropped
  assign wr_hit = we
               && ({1'b0, we_ch}   < (CH_W+1)'(NUM_CH))
               && ({1'b0, we_addr} < (ADDR_W+1)'(DEPTH));
  assign rd_in_rng = ({1'b0, rd_ch}   < (CH_W+1)'(NUM_CH))
                  && ({1'b0, rd_addr} < (ADDR_W+1)'(DEPTH));

  always_ff @(negedge Sclk) begin
    if (wr_hit) mem[we_ch][we_addr] <= data_in;
  end

`ifdef RJ_MEM_PARITY_EN
  logic par_mem [NUM_CH][DEPTH];
  logic perr_q, perr_d;

  always_ff @(negedge Sclk) begin
    if (wr_hit) par_mem[we_ch][we_addr] <= rj_parity(64'(data_in));
  end
`endif

  always_comb begin
    rj_d  = '0;
    vld_d = 1'b0;
`ifdef RJ_MEM_PARITY_EN
    perr_d = 1'b0;
`endif
    if (rd_en) begin
      vld_d = 1'b1;
      if (rd_in_rng) begin
        if (wr_hit && (we_ch == rd_ch) && (we_addr == rd_addr)) begin
          rj_d = data_in;
        end else begin
          rj_d = mem[rd_ch][rd_addr];
`ifdef RJ_MEM_PARITY_EN
          perr_d = par_mem[rd_ch][rd_addr] != rj_parity(64'(mem[rd_ch][rd_addr]));
`endif
        end
      end
    end
  end

  always_ff @(negedge Sclk) begin
    if (Reset) begin
      rj_q  <= '0;
      vld_q <= 1'b0;
`ifdef RJ_MEM_PARITY_EN
      perr_q <= 1'b0;
`endif
    end else begin
      rj_q  <= rj_d;
      vld_q <= vld_d;
`ifdef RJ_MEM_PARITY_EN
      perr_q <= perr_d;
`endif
    end
  end

  assign Rj       = rj_q;
  assign rd_valid = vld_q;
`ifdef RJ_MEM_PARITY_EN
  assign par_err  = perr_q;
`endif

endmodule

// File: tb/tb_rj_mem_bank.sv
// Scoreboard bench for rj_mem_bank: directed load/bypass/reset scenarios, then random traffic.
`timescale 1ns/1ps
module tb_rj_mem_bank;

  localparam int unsigned DW = 16;
  localparam int unsigned DP = 16;
  localparam int unsigned NC = 2;
  localparam int unsigned AW = 4;
  localparam int unsigned CW = 1;
  localparam int unsigned LW = CW + AW + 1;

  logic Sclk = 1'b1;
  always #5 Sclk = ~Sclk;

  logic          Reset, Frame, load_en, wr_en, rd_en;
  logic [CW-1:0] wr_ch, rd_ch;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] data_in;
  logic [DW-1:0] Rj;
  logic          rd_valid, load_done;
  logic [LW-1:0] load_cnt;
`ifdef RJ_MEM_PARITY_EN
  logic          par_err;
  logic          par_err3;
`endif

  rj_mem_bank #(.DATA_W(DW), .DEPTH(DP), .NUM_CH(NC)) u_dut (
    .Sclk(Sclk), .Reset(Reset), .Frame(Frame), .load_en(load_en), .wr_en(wr_en),
    .wr_ch(wr_ch), .wr_addr(wr_addr), .data_in(data_in), .rd_en(rd_en),
    .rd_ch(rd_ch), .rd_addr(rd_addr), .Rj(Rj), .rd_valid(rd_valid),
    .load_done(load_done), .load_cnt(load_cnt)
`ifdef RJ_MEM_PARITY_EN
    , .par_err(par_err)
`endif
  );

  // Three channels of five words: exercises unused channel and address codes
  logic       zero3 = 1'b0;
  logic [1:0] wr_ch3 = '0, rd_ch3 = '0;
  logic [2:0] wr_addr3 = '0, rd_addr3 = '0;
  logic       rd_en3 = 1'b0;
  logic [DW-1:0] Rj3;
  logic       rd_valid3, load_done3;
  logic [5:0] load_cnt3;

  rj_mem_bank #(.DATA_W(DW), .DEPTH(5), .NUM_CH(3)) u_dut3 (
    .Sclk(Sclk), .Reset(Reset), .Frame(zero3), .load_en(zero3), .wr_en(zero3),
    .wr_ch(wr_ch3), .wr_addr(wr_addr3), .data_in(data_in), .rd_en(rd_en3),
    .rd_ch(rd_ch3), .rd_addr(rd_addr3), .Rj(Rj3), .rd_valid(rd_valid3),
    .load_done(load_done3), .load_cnt(load_cnt3)
`ifdef RJ_MEM_PARITY_EN
    , .par_err(par_err3)
`endif
  );

  typedef struct {
    logic          vld;
    logic [DW-1:0] rj;
    bit            chk_rj;
    logic          done;
    logic [LW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_err = 0;

  // Reference model: load progress is a linear word count, memory a plain array
  int            m_state = 0;  // 0 idle, 1 loading, 2 ready
  int            m_cnt   = 0;
  bit            m_done  = 1'b0;
  logic [DW-1:0] m_mem   [NC][DP];
  bit            m_known [NC][DP];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  task automatic step(input bit rst, input bit le, input bit we, input bit fr, input bit re,
                      input int wc, input int wa, input int rc, input int ra,
                      input logic [DW-1:0] d);
    exp_t e;
    bit   do_w;
    int   tc, ta;
    Reset = rst; load_en = le; wr_en = we; Frame = fr; rd_en = re;
    wr_ch = CW'(wc); wr_addr = AW'(wa); rd_ch = CW'(rc); rd_addr = AW'(ra); data_in = d;
    e.vld = 1'b0; e.rj = '0; e.chk_rj = 1'b1;
    do_w = 1'b0; tc = 0; ta = 0;
    if (rst) begin
      m_state = 0; m_cnt = 0; m_done = 1'b0;
    end else begin
      if (le) begin
        m_state = 1; m_cnt = 0; m_done = 1'b0;
      end else if (m_state == 1 && we && fr) begin
        do_w = 1'b1; tc = m_cnt / DP; ta = m_cnt % DP;
        m_cnt++;
        if (m_cnt == NC * DP) begin m_state = 2; m_done = 1'b1; end
      end else if (m_state == 2 && we && fr && wc < NC && wa < DP) begin
        do_w = 1'b1; tc = wc; ta = wa;
      end
      if (re) begin
        e.vld = 1'b1;
        if (rc >= NC || ra >= DP) e.rj = '0;
        else if (do_w && tc == rc && ta == ra) e.rj = d;
        else if (m_known[rc][ra]) e.rj = m_mem[rc][ra];
        else e.chk_rj = 1'b0;
      end
      if (do_w) begin m_mem[tc][ta] = d; m_known[tc][ta] = 1'b1; end
    end
    e.done = m_done;
    e.cnt  = LW'(m_cnt);
    @(negedge Sclk);
    #1;
    q.push_back(e);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
  endtask

  task automatic wr(input logic [DW-1:0] d);
    step(0, 0, 1, 1, 0, 0, 0, 0, 0, d);
  endtask

  task automatic rd(input int c, input int a);
    step(0, 0, 0, 0, 1, 0, 0, c, a, '0);
  endtask

  // Monitor: every edge produces a response; compare it half a cycle later
  initial begin
    exp_t e;
    forever begin
      @(posedge Sclk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rd_valid", 32'(rd_valid), 32'(e.vld));
        if (e.chk_rj) chk("Rj", 32'(Rj), 32'(e.rj));
        chk("load_done", 32'(load_done), 32'(e.done));
        chk("load_cnt", 32'(load_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    Reset = 1'b1; Frame = 1'b0; load_en = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_ch = '0; wr_addr = '0; rd_ch = '0; rd_addr = '0; data_in = '0;

    step(1, 0, 0, 0, 0, 0, 0, 0, 0, '0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, '0);
    chk("reset_Rj", 32'(Rj), 32'h0);
    chk("reset_done", 32'(load_done), 32'h0);
    chk("reset_cnt3", 32'(load_cnt3), 32'h0);

    // Full bulk load, then read ch1 addr3
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 32; i++) begin
      if (i == 31) chk("pre_done", 32'(load_done), 32'h0);
      wr(16'h1000 + 16'(i));
    end
    chk("load_done_32", 32'(load_done), 32'h1);
    rd(1, 3);
    chk("rd_1_3", 32'(Rj), 32'h1013);
    chk("rd_1_3_vld", 32'(rd_valid), 32'h1);

    idle();
    chk("rd_off_vld", 32'(rd_valid), 32'h0);
    chk("rd_off_Rj", 32'(Rj), 32'h0);

    // Write-first bypass in READY
    step(0, 0, 1, 1, 1, 0, 5, 0, 5, 16'hBEEF);
    chk("bypass", 32'(Rj), 32'hBEEF);
    rd(0, 5);

    // Reload with a three-edge Frame gap
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 5; i++) wr(16'h2000 + 16'(i));
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 1, 9, 0, 0, 16'hFFFF);
    chk("gap_cnt", 32'(load_cnt), 32'd5);
    for (int i = 5; i < 9; i++) wr(16'h2000 + 16'(i));
    for (int a = 0; a < 10; a++) rd(0, a);
    rd(0, 5);
    chk("gap_seq", 32'(Rj), 32'h2005);

    // Reset part-way through a load, with a concurrent write and read
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 10; i++) wr(16'h3000 + 16'(i));
    step(1, 0, 1, 1, 1, 0, 0, 0, 0, 16'h5555);
    chk("rst_mid_done", 32'(load_done), 32'h0);
    chk("rst_mid_Rj", 32'(Rj), 32'h0);
    chk("rst_mid_cnt", 32'(load_cnt), 32'h0);
    step(0, 0, 1, 1, 0, 0, 0, 0, 0, 16'hDEAD);
    for (int a = 0; a < 11; a++) rd(0, a);
    rd(0, 0);
    chk("kept_0", 32'(Rj), 32'h3000);
    rd(1, 3);

    // Unused channel / address codes on the 3x5 instance
    rd_en3 = 1'b1; rd_ch3 = 2'd3; rd_addr3 = 3'd1;
    idle();
    chk("oor_ch_Rj", 32'(Rj3), 32'h0);
    chk("oor_ch_vld", 32'(rd_valid3), 32'h1);
    rd_ch3 = 2'd0; rd_addr3 = 3'd6;
    idle();
    chk("oor_addr_vld", 32'(rd_valid3), 32'h1);
    chk("oor_addr_Rj", 32'(Rj3), 32'h0);
    rd_en3 = 1'b0;
    idle();
    chk("d3_off_vld", 32'(rd_valid3), 32'h0);

`ifdef RJ_MEM_PARITY_EN
    u_dut.par_mem[0][2] = ~u_dut.par_mem[0][2];
    rd(0, 2);
    chk("par_err_flip", 32'(par_err), 32'h1);
    rd(0, 3);
    chk("par_err_clean", 32'(par_err), 32'h0);
    u_dut.par_mem[0][2] = ~u_dut.par_mem[0][2];
`endif

    // Random traffic
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, '0);
    for (int n = 0; n < 500; n++) begin
      r = int'($urandom_range(0, 249));
      step(r == 0, r == 1, $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
           $urandom_range(0, 3) != 0,
           int'($urandom_range(0, NC - 1)), int'($urandom_range(0, DP - 1)),
           int'($urandom_range(0, NC - 1)), int'($urandom_range(0, DP - 1)),
           16'($urandom));
    end

    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge Sclk);
    #1;
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
